puf_batch_sequencer: RTL and testbench
======================================

// Module: puf_batch_sequencer
// PURPOSE
//  Host-side sequencer that feeds the serial PUF transmit/receive stage. Fetches
//  challenge pairs (A,B) byte-wise from the SIRC input memory, presents them, pulses
//  ex_start, waits for ex_done, then writes the four 128-bit responses byte-wise to
//  SIRC output memory. Repeats for num_challenges pairs.
// PARAMETERS
//  IN_ADDR_W   14      input memory byte-address width
//  OUT_ADDR_W  14      output memory byte-address width
//  START_HOLD  8       clk cycles ex_start held high (>=4: PUF stage samples on PH1 = clk/4)
//  TIMEOUT     4096    clk cycles allowed from ex_start rise to ex_done rise
// PORTS
//  clk            in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  start          in   1           begin batch (sampled only in IDLE)
//  num_challenges in   16          number of challenge pairs in batch
//  busy           out  1           high from start accept until done
//  done           out  1           one-cycle pulse at batch end
//  err_timeout    out  1           sticky; set on ex_done timeout, cleared on next start
//  in_rd_req      out  1           input memory read request
//  in_rd_addr     out  IN_ADDR_W   input byte address
//  in_rd_ack      in   1           read ack; in_rd_data valid this cycle
//  in_rd_data     in   8           read data
//  challengeA     out  128         to PUF stage
//  challengeB     out  128         to PUF stage
//  ex_start       out  1           PUF stage execution start
//  ex_done        in   1           PUF stage completion level
//  responseUp/responseUpNot/responseDown/responseDownNot  in  128 each  PUF results
//  out_wr_req     out  1           output memory write request
//  out_wr_addr    out  OUT_ADDR_W  output byte address
//  out_wr_data    out  8           write data
//  out_wr_ack     in   1           write ack
// BEHAVIOUR
//  Reset: state IDLE; busy,done,err_timeout,in_rd_req,out_wr_req,ex_start=0;
//   addresses, challengeA/B, index, counters = 0. Reset mid-batch aborts immediately.
//  States: IDLE -> LOAD -> FIRE -> WAIT -> STORE -> (LOAD | FIN) -> IDLE.
//  IDLE: start=1 -> busy=1, err_timeout=0, idx=0; if num_challenges==0 go FIN, else LOAD.
//   start while busy is ignored; num_challenges latched at accept.
//  LOAD: 32 reads, k=0..31, in_rd_addr = idx*32+k. req held, addr stable until ack;
//   one outstanding. k<16 -> challengeA[8k+7:8k]; k>=16 -> challengeB[8(k-16)+7:8(k-16)].
//   req drops the cycle after ack; next req issued the following cycle.
//  FIRE: ex_start=1 for exactly START_HOLD cycles; challengeA/B stable from here to end
//   of WAIT. Timeout counter starts at ex_start rise.
//  WAIT: ex_done registered once (ex_done_q); advance on ex_done_q 0->1 edge only
//   (stale high level from previous run is not completion). Counter reaching TIMEOUT:
//   err_timeout=1, go FIN (remaining pairs skipped, no writes for this pair).
//  STORE: 64 writes, j=0..63, out_wr_addr = idx*64+j; req/addr/data held until ack.
//   j 0-15 responseUp, 16-31 responseUpNot, 32-47 responseDown, 48-63 responseDownNot;
//   byte m of each vector = bits [8m+7:8m]. Responses captured into a 512-bit
//   holding register on WAIT exit; writes use the copy.
//  After last write: idx+1; if idx+1==num_challenges -> FIN else LOAD.
//  FIN: done=1 one cycle, busy=0 same cycle, -> IDLE.
//  Address arithmetic truncates to IN_ADDR_W/OUT_ADDR_W (wraps silently).
//  Acks asserted without a pending req are ignored.
// TESTING
//  1 reset, start, num=1, A=0x0F..00 ramp bytes, B=0xFF..F0, model PUF echoes A into
//    all responses -> 32 reads addr 0-31, 64 writes addr 0-63, byte j = j%16, done pulse.
//  2 num=3, random ack delays 0-5 cycles -> reads addr 0-95 in order, writes 0-191,
//    ex_start pulses 3x each 8 cycles wide, single done.
//  3 num=0 -> done one cycle after start accept, no memory requests, no ex_start.
//  4 ex_done held high from prior run, never toggles -> err_timeout=1 after 4096 cycles,
//    no writes, done pulses; next start clears err_timeout.
//  5 reset asserted mid-STORE (j=20) -> next cycle all outputs at reset values; new start
//    restarts at read addr 0.
//  6 start pulsed during LOAD -> ignored; batch count unchanged.

Source files
------------

// File: rtl/puf_batch_sequencer.sv
// puf_batch_sequencer
// Host-side batch engine for the serial PUF stage. For each challenge pair it
// reads 32 bytes (A then B) from input memory, fires the PUF stage, waits for a
// fresh completion edge (bounded by a timeout), snapshots the four responses and
// writes them as 64 bytes to output memory.
module puf_batch_sequencer #(
    parameter int IN_ADDR_W  = 14,
    parameter int OUT_ADDR_W = 14,
    parameter int START_HOLD = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           num_challenges,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  in_rd_req,
    output logic [IN_ADDR_W-1:0]  in_rd_addr,
    input  logic                  in_rd_ack,
    input  logic [7:0]            in_rd_data,
    output logic [127:0]          challengeA,
    output logic [127:0]          challengeB,
    output logic                  ex_start,
    input  logic                  ex_done,
    input  logic [127:0]          responseUp,
    input  logic [127:0]          responseUpNot,
    input  logic [127:0]          responseDown,
    input  logic [127:0]          responseDownNot,
    output logic                  out_wr_req,
    output logic [OUT_ADDR_W-1:0] out_wr_addr,
    output logic [7:0]            out_wr_data,
    input  logic                  out_wr_ack
);

    // Counter covers both the START_HOLD window and the full timeout window.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_STORE,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        num_q, num_d;
    logic [15:0]        idx_q, idx_d;
    logic [4:0]         rd_k_q, rd_k_d;
    logic [5:0]         wr_j_q, wr_j_d;
    logic               rd_req_q, rd_req_d;
    logic               wr_req_q, wr_req_d;
    logic [255:0]       chal_q, chal_d;
    logic [511:0]       resp_q, resp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               ex_done_q, ex_done_d;
    logic               ex_done_prev_q, ex_done_prev_d;
    logic [15:0]        idx_inc;
    logic               done_rise;

    // Only a fresh 0->1 transition counts; a level left high by the previous
    // run must not be mistaken for completion.
    assign done_rise = ex_done_q & ~ex_done_prev_q;

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        idx_d          = idx_q;
        rd_k_d         = rd_k_q;
        wr_j_d         = wr_j_q;
        rd_req_d       = rd_req_q;
        wr_req_d       = wr_req_q;
        chal_d         = chal_q;
        resp_d         = resp_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        ex_done_d      = ex_done;
        ex_done_prev_d = ex_done_q;
        idx_inc        = idx_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    idx_d  = '0;
                    num_d  = num_challenges;
                    rd_k_d = '0;
                    wr_j_d = '0;
                    if (num_challenges == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_LOAD;
                        rd_req_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (rd_req_q) begin
                    if (in_rd_ack) begin
                        // Bytes 0-15 fill A, 16-31 fill B: one flat 256-bit image.
                        chal_d[{rd_k_q, 3'b000} +: 8] = in_rd_data;
                        rd_req_d = 1'b0;
                        rd_k_d   = rd_k_q + 5'd1;
                        if (rd_k_q == 5'd31) begin
                            state_d = S_FIRE;
                            cnt_d   = '0;
                        end
                    end
                end else begin
                    rd_req_d = 1'b1;
                end
            end
            S_FIRE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_rise) begin
                    resp_d   = {responseDownNot, responseDown, responseUpNot, responseUp};
                    wr_j_d   = '0;
                    wr_req_d = 1'b1;
                    state_d  = S_STORE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the rest of the batch; nothing is written for this pair.
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_STORE: begin
                if (wr_req_q) begin
                    if (out_wr_ack) begin
                        wr_req_d = 1'b0;
                        wr_j_d   = wr_j_q + 6'd1;
                        if (wr_j_q == 6'd63) begin
                            idx_d = idx_inc;
                            if (idx_inc == num_q) begin
                                state_d = S_FIN;
                            end else begin
                                state_d  = S_LOAD;
                                rd_k_d   = '0;
                                rd_req_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    wr_req_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-batch aborts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            num_q          <= '0;
            idx_q          <= '0;
            rd_k_q         <= '0;
            wr_j_q         <= '0;
            rd_req_q       <= 1'b0;
            wr_req_q       <= 1'b0;
            chal_q         <= '0;
            resp_q         <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            ex_done_q      <= 1'b0;
            ex_done_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            idx_q          <= idx_d;
            rd_k_q         <= rd_k_d;
            wr_j_q         <= wr_j_d;
            rd_req_q       <= rd_req_d;
            wr_req_q       <= wr_req_d;
            chal_q         <= chal_d;
            resp_q         <= resp_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            ex_done_q      <= ex_done_d;
            ex_done_prev_q <= ex_done_prev_d;
        end
    end

    // Moore outputs; addresses wrap silently to the memory widths.
    assign busy        = (state_q == S_LOAD) || (state_q == S_FIRE) ||
                         (state_q == S_WAIT) || (state_q == S_STORE);
    assign done        = (state_q == S_FIN);
    assign ex_start    = (state_q == S_FIRE);
    assign err_timeout = err_q;
    assign in_rd_req   = rd_req_q;
    assign out_wr_req  = wr_req_q;
    assign in_rd_addr  = IN_ADDR_W'({idx_q, rd_k_q});
    assign out_wr_addr = OUT_ADDR_W'({idx_q, wr_j_q});
    assign out_wr_data = resp_q[{wr_j_q, 3'b000} +: 8];
    assign challengeA  = chal_q[127:0];
    assign challengeB  = chal_q[255:128];

endmodule

// File: tb/tb_puf_batch_sequencer.sv
// Self-checking bench for puf_batch_sequencer: memory/PUF responders with random
// ack timing, a transaction-level expectation model derived from memory contents,
// and one negedge compare process.
module tb_puf_batch_sequencer;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [15:0]  num_challenges;
    logic         busy, done, err_timeout;
    logic         in_rd_req, in_rd_ack;
    logic [13:0]  in_rd_addr;
    logic [7:0]   in_rd_data;
    logic [127:0] challengeA, challengeB;
    logic         ex_start, ex_done;
    logic [127:0] responseUp, responseUpNot, responseDown, responseDownNot;
    logic         out_wr_req, out_wr_ack;
    logic [13:0]  out_wr_addr;
    logic [7:0]   out_wr_data;

    puf_batch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_challenges(num_challenges),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .in_rd_req(in_rd_req), .in_rd_addr(in_rd_addr), .in_rd_ack(in_rd_ack),
        .in_rd_data(in_rd_data), .challengeA(challengeA), .challengeB(challengeB),
        .ex_start(ex_start), .ex_done(ex_done),
        .responseUp(responseUp), .responseUpNot(responseUpNot),
        .responseDown(responseDown), .responseDownNot(responseDownNot),
        .out_wr_req(out_wr_req), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data), .out_wr_ack(out_wr_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem [0:16383];
    bit echo_mode, lit_mode, stuck_mode, spur_en;

    // monitor-owned event counters; main-owned baselines per batch
    int rd_cnt, wr_cnt, pulse_cnt, done_cnt, rise_cyc;
    int rd_base, wr_base, pulse_base, done_base;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_vec(input int base);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = mem[14'(base + k)];
        return v;
    endfunction

    // Reference PUF behaviour: four vectors derived from the challenge pair.
    function automatic logic [127:0] puf_fn(input logic [127:0] a, input logic [127:0] b,
                                            input int v, input bit echo);
        if (echo) return a;
        case (v)
            0:       return a ^ b;
            1:       return ~(a ^ b);
            2:       return {a[63:0], b[127:64]};
            default: return a + b;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // input memory responder: random 0-5 cycle ack latency, optional stray acks
    initial begin
        int dly;
        bit armed;
        in_rd_ack = 1'b0; in_rd_data = 8'h00; armed = 1'b0; dly = 0;
        forever begin
            @(posedge clk); #1;
            if (in_rd_ack) begin
                in_rd_ack = 1'b0;
            end else if (in_rd_req) begin
                if (!armed) begin dly = $urandom_range(0, 5); armed = 1'b1; end
                if (dly == 0) begin
                    in_rd_ack = 1'b1; in_rd_data = mem[in_rd_addr]; armed = 1'b0;
                end else dly--;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                in_rd_ack = 1'b1; in_rd_data = 8'($urandom);
            end
        end
    end

    // output memory responder
    initial begin
        int dly;
        bit armed;
        out_wr_ack = 1'b0; armed = 1'b0; dly = 0;
        forever begin
            @(posedge clk); #1;
            if (out_wr_ack) begin
                out_wr_ack = 1'b0;
            end else if (out_wr_req) begin
                if (!armed) begin dly = $urandom_range(0, 5); armed = 1'b1; end
                if (dly == 0) begin out_wr_ack = 1'b1; armed = 1'b0; end
                else dly--;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                out_wr_ack = 1'b1;
            end
        end
    end

    // PUF stage model: drops done on fire, answers some cycles after ex_start falls
    initial begin
        logic [127:0] a, b;
        ex_done = 1'b0;
        responseUp = '0; responseUpNot = '0; responseDown = '0; responseDownNot = '0;
        forever begin
            @(posedge clk); #1;
            if (stuck_mode) begin
                ex_done = 1'b1;
            end else if (ex_start) begin
                ex_done = 1'b0;
                a = challengeA; b = challengeB;
                while (ex_start) begin @(posedge clk); #1; end
                repeat ($urandom_range(2, 20)) @(posedge clk);
                #1;
                responseUp      = puf_fn(a, b, 0, echo_mode);
                responseUpNot   = puf_fn(a, b, 1, echo_mode);
                responseDown    = puf_fn(a, b, 2, echo_mode);
                responseDownNot = puf_fn(a, b, 3, echo_mode);
                ex_done = 1'b1;
            end
        end
    end

    // compare process: every transaction and control event against the model
    initial begin
        int w, p, j, run_len;
        bit es_prev, done_prev;
        logic [127:0] ev;
        rd_cnt = 0; wr_cnt = 0; pulse_cnt = 0; done_cnt = 0; rise_cyc = 0;
        run_len = 0; es_prev = 1'b0; done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                es_prev = 1'b0; done_prev = 1'b0; run_len = 0;
                continue;
            end
            if (in_rd_req && in_rd_ack) begin
                w = rd_cnt - rd_base;
                check("rd_addr", 128'(in_rd_addr), 128'(14'(w)));
                $display("RD  n=%0d addr=%0d data=%02h", w, in_rd_addr, in_rd_data);
                rd_cnt++;
            end
            if (out_wr_req && out_wr_ack) begin
                w = wr_cnt - wr_base;
                p = w / 64;
                j = w % 64;
                ev = puf_fn(mem_vec(p*32), mem_vec(p*32 + 16), j / 16, echo_mode);
                check("wr_addr", 128'(out_wr_addr), 128'(14'(w)));
                check("wr_data", 128'(out_wr_data), 128'(ev[8*(j%16) +: 8]));
                if (lit_mode) check("wr_data_literal", 128'(out_wr_data), 128'(j % 16));
                $display("WR  n=%0d addr=%0d data=%02h", w, out_wr_addr, out_wr_data);
                wr_cnt++;
            end
            if (ex_start && !es_prev) begin
                p = pulse_cnt - pulse_base;
                check("challengeA", challengeA, mem_vec(p*32));
                check("challengeB", challengeB, mem_vec(p*32 + 16));
                check("reads_before_fire", 128'(rd_cnt - rd_base), 128'(32*(p+1)));
                $display("EX  pair=%0d A=%h B=%h", p, challengeA, challengeB);
                pulse_cnt++;
                rise_cyc = cyc;
                run_len = 1;
            end else if (ex_start) begin
                run_len++;
            end
            if (!ex_start && es_prev) check("ex_start_width", 128'(run_len), 128'(8));
            if (done) begin
                check("busy_low_at_done", 128'(busy), 128'(0));
                check("done_single_cycle", 128'(done_prev), 128'(0));
                $display("DONE err_timeout=%0d", err_timeout);
                done_cnt++;
            end
            if (in_rd_req || out_wr_req || ex_start) check("busy_when_active", 128'(busy), 128'(1));
            es_prev = ex_start;
            done_prev = done;
        end
    end

    task automatic check_reset(input string tag);
        $display("RST check %s", tag);
        check({tag, "_busy"},        128'(busy), 128'(0));
        check({tag, "_done"},        128'(done), 128'(0));
        check({tag, "_err"},         128'(err_timeout), 128'(0));
        check({tag, "_rd_req"},      128'(in_rd_req), 128'(0));
        check({tag, "_wr_req"},      128'(out_wr_req), 128'(0));
        check({tag, "_ex_start"},    128'(ex_start), 128'(0));
        check({tag, "_rd_addr"},     128'(in_rd_addr), 128'(0));
        check({tag, "_wr_addr"},     128'(out_wr_addr), 128'(0));
        check({tag, "_wr_data"},     128'(out_wr_data), 128'(0));
        check({tag, "_challengeA"},  challengeA, 128'(0));
        check({tag, "_challengeB"},  challengeB, 128'(0));
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        rd_base = rd_cnt; wr_base = wr_cnt; pulse_base = pulse_cnt; done_base = done_cnt;
        num_challenges = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("START num=%0d", n);
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != done_base) break;
        end
        check("done_within_budget", 128'(i < budget), 128'(1));
    endtask

    task automatic check_counts(input int reads, input int writes, input int pulses);
        repeat (6) @(negedge clk);
        #1;
        check("read_count",  128'(rd_cnt - rd_base), 128'(reads));
        check("write_count", 128'(wr_cnt - wr_base), 128'(writes));
        check("fire_count",  128'(pulse_cnt - pulse_base), 128'(pulses));
        check("done_count",  128'(done_cnt - done_base), 128'(1));
        check("idle_busy",   128'(busy), 128'(0));
    endtask

    initial begin
        int i;
        reset = 1'b1; start = 1'b0; num_challenges = '0;
        echo_mode = 1'b0; lit_mode = 1'b0; stuck_mode = 1'b0; spur_en = 1'b0;
        rd_base = 0; wr_base = 0; pulse_base = 0; done_base = 0;
        for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1 reset = 1'b0;

        // 1: single pair, ramp A / high-nibble B, PUF echoes A
        for (int k = 0; k < 16; k++) begin mem[k] = 8'(k); mem[16+k] = 8'(8'hF0 + k); end
        echo_mode = 1'b1; lit_mode = 1'b1;
        do_start(1);
        @(negedge clk); #1;
        check("busy_after_accept", 128'(busy), 128'(1));
        wait_done(3000);
        check_counts(32, 64, 1);
        echo_mode = 1'b0; lit_mode = 1'b0;

        // 2: three pairs, random data, random latencies, stray acks
        fill_random();
        spur_en = 1'b1;
        do_start(3);
        wait_done(6000);
        check_counts(96, 192, 3);

        // 3: empty batch
        do_start(0);
        @(negedge clk); #1;
        check("num0_done", 128'(done), 128'(1));
        check("num0_busy", 128'(busy), 128'(0));
        repeat (10) @(negedge clk);
        #1;
        check("num0_reads",  128'(rd_cnt - rd_base), 128'(0));
        check("num0_writes", 128'(wr_cnt - wr_base), 128'(0));
        check("num0_fires",  128'(pulse_cnt - pulse_base), 128'(0));
        check("num0_dones",  128'(done_cnt - done_base), 128'(1));

        // 4: completion level stuck high -> timeout, batch abandoned
        spur_en = 1'b0;
        stuck_mode = 1'b1;
        fill_random();
        do_start(2);
        for (i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (err_timeout) break;
        end
        check("timeout_seen", 128'(i < 6000), 128'(1));
        check("timeout_cycles", 128'(cyc - rise_cyc), 128'(4096));
        check("timeout_done", 128'(done), 128'(1));
        check_counts(32, 0, 1);
        check("err_sticky", 128'(err_timeout), 128'(1));
        stuck_mode = 1'b0;
        do_start(0);
        @(negedge clk); #1;
        check("err_cleared", 128'(err_timeout), 128'(0));

        // 5: reset during the output phase, then a clean restart
        fill_random();
        do_start(1);
        for (i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if ((wr_cnt - wr_base) >= 20 && out_wr_req) break;
        end
        check("reached_store", 128'(i < 4000), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset("mid_store");
        do_start(1);
        for (i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (in_rd_req) break;
        end
        check("restart_rd_addr", 128'(in_rd_addr), 128'(0));
        wait_done(3000);
        check_counts(32, 64, 1);

        // 6: start re-pulsed while loading is ignored
        spur_en = 1'b1;
        fill_random();
        do_start(2);
        for (i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if ((rd_cnt - rd_base) >= 5) break;
        end
        @(posedge clk); #1;
        num_challenges = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check("busy_after_ignored_start", 128'(busy), 128'(1));
        wait_done(5000);
        check_counts(64, 128, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
